// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-requester my_mem controller.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package mem_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RWAIT = 2'd3
  } arb_state_t;

  // my_mem stores bit 8 as the XOR of the data byte (total ones count even)
  function automatic logic even_parity(input logic [DATA_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among NUM_REQ requests, starting the search just after 'last'.
// Latency: purely combinational; the 'last' pointer is owned by the caller.
// Backpressure: none; pick is all-zero when no request is present.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx
);

  logic             found;
  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk the requesters in rotating order last+1, last+2, ... and keep the first hit
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found          = 1'b1;
        pick[cand_idx] = 1'b1;
        pick_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port my_mem between NUM_REQ masters, one transaction at a time.
// Latency: write grant 1 cycle after sampling (2 cycles/txn); read data 3 cycles after sampling.
// Backpressure: requester holds req/we/addr/wdata until it sees its one-cycle gnt pulse.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = mem_arb_pkg::ADDR_W,
  parameter int DATA_W  = mem_arb_pkg::DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         we,
  input  logic [NUM_REQ*ADDR_W-1:0]  addr,
  input  logic [NUM_REQ*DATA_W-1:0]  wdata,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         rvalid,
  output logic [DATA_W-1:0]          rdata,
  output logic                       parity_err,
  output logic [7:0]                 err_cnt,
  output logic                       busy,
  output logic                       mem_write,
  output logic                       mem_read,
  output logic [ADDR_W-1:0]          mem_address,
  output logic [DATA_W-1:0]          mem_data_in,
  input  logic [DATA_W:0]            mem_data_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   win;
  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               rd_par_bad;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req      (req),
    .last     (last),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  assign rd_par_bad = (even_parity(mem_data_out[DATA_W-1:0]) != mem_data_out[DATA_W]);

  // Transaction sequencer: strobes, grant/valid pulses and read capture are all registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= IDX_W'(NUM_REQ - 1);
      win         <= '0;
      gnt         <= '0;
      rvalid      <= '0;
      rdata       <= '0;
      parity_err  <= 1'b0;
      err_cnt     <= '0;
      busy        <= 1'b0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
    end else begin
      // pulses default low; address/data hold their last values
      gnt        <= '0;
      rvalid     <= '0;
      parity_err <= 1'b0;
      mem_write  <= 1'b0;
      mem_read   <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            // commit the winner now; later changes on its req are ignored
            last        <= pick_idx;
            win         <= pick_idx;
            gnt         <= pick;
            busy        <= 1'b1;
            mem_address <= addr[pick_idx*ADDR_W +: ADDR_W];
            if (we[pick_idx]) begin
              state       <= WRITE;
              mem_write   <= 1'b1;
              mem_data_in <= wdata[pick_idx*DATA_W +: DATA_W];
            end else begin
              state    <= READ;
              mem_read <= 1'b1;
            end
          end
        end
        WRITE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        READ: begin
          // my_mem registers data_out on this edge; sample it in RWAIT
          state <= RWAIT;
        end
        RWAIT: begin
          rdata      <= mem_data_out[DATA_W-1:0];
          rvalid     <= NUM_REQ'(1) << win;
          parity_err <= rd_par_bad;
          if (rd_par_bad && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural my_mem and a transaction-level model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_mem_arbiter;

  localparam int NR = 2;
  localparam int AW = 16;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR-1:0]     we = '0;
  logic [NR*AW-1:0]  addr = '0;
  logic [NR*DW-1:0]  wdata = '0;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     rvalid;
  logic [DW-1:0]     rdata;
  logic              parity_err;
  logic [7:0]        err_cnt;
  logic              busy;
  logic              mem_write;
  logic              mem_read;
  logic [AW-1:0]     mem_address;
  logic [DW-1:0]     mem_data_in;
  logic [DW:0]       mem_data_out = '0;

  // behavioural my_mem: addresses used by the bench all fit in the low byte
  logic [7:0]        mem_arr [0:255] = '{default: 8'h00};
  logic              corrupt = 1'b0;

  // reference model state
  logic [7:0]        exp_mem [int];
  int                m_last = NR - 1;
  int                n_tests = 0;
  int                n_fail = 0;

  mem_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .we           (we),
    .addr         (addr),
    .wdata        (wdata),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .parity_err   (parity_err),
    .err_cnt      (err_cnt),
    .busy         (busy),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  // synchronous single-port memory; corrupt flips the stored parity bit on reads
  always @(posedge clk) begin
    if (mem_write) mem_arr[mem_address[7:0]] <= mem_data_in;
    if (mem_read) mem_data_out <= {(^mem_arr[mem_address[7:0]]) ^ corrupt, mem_arr[mem_address[7:0]]};
  end

  // round-robin rule: first pending requester found starting at last+1
  function automatic int rr_pick(input logic [NR-1:0] p, input int last);
    for (int k = 1; k <= NR; k++)
      if (p[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  function automatic logic [7:0] mem_lookup(input logic [AW-1:0] a);
    return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : 8'h00;
  endfunction

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    we[i] = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    req = '0;
    we = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_last = NR - 1;
  endtask

  task automatic test_reset();
    req = '0;
    rst_n = 1'b0;
    #1;
    n_tests++; if ({gnt, rvalid, parity_err, mem_write, mem_read, busy} !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl_async: got %b expected 0", {gnt, rvalid, parity_err, mem_write, mem_read, busy}); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if ({rdata, err_cnt, mem_address, mem_data_in} !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {rdata, err_cnt, mem_address, mem_data_in}); end
    rst_n = 1'b1;
    m_last = NR - 1;
    @(negedge clk);
    n_tests++; if ({gnt, rvalid, mem_write, mem_read, busy} !== 7'b0) begin n_fail++; $display("FAIL reset_idle: got %b expected 0", {gnt, rvalid, mem_write, mem_read, busy}); end
  endtask

  task automatic test_write();
    @(posedge clk); #1;
    set_req(0, 1'b1, 16'h0010, 8'hA5);
    @(negedge clk);
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL wr_pre_gnt: got %b expected 00", gnt); end
    @(negedge clk);
    n_tests++; if ({gnt, mem_write, mem_read, busy} !== 5'b01101) begin n_fail++; $display("FAIL wr_strobes: got %b expected 01101", {gnt, mem_write, mem_read, busy}); end
    n_tests++; if (mem_address !== 16'h0010) begin n_fail++; $display("FAIL wr_addr: got %h expected 0010", mem_address); end
    n_tests++; if (mem_data_in !== 8'hA5) begin n_fail++; $display("FAIL wr_data: got %h expected a5", mem_data_in); end
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    n_tests++; if ({gnt, mem_write, busy} !== 4'b0000) begin n_fail++; $display("FAIL wr_done: got %b expected 0000", {gnt, mem_write, busy}); end
    exp_mem[16'h0010] = 8'hA5;
    m_last = 0;
  endtask

  task automatic test_read();
    @(posedge clk); #1;
    set_req(1, 1'b0, 16'h0010, 8'h00);
    @(negedge clk);
    @(negedge clk);
    n_tests++; if ({gnt, mem_read, mem_write} !== 4'b1010) begin n_fail++; $display("FAIL rd_strobes: got %b expected 1010", {gnt, mem_read, mem_write}); end
    n_tests++; if (mem_address !== 16'h0010) begin n_fail++; $display("FAIL rd_addr: got %h expected 0010", mem_address); end
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(negedge clk);
    n_tests++; if ({gnt, rvalid, busy} !== 5'b00001) begin n_fail++; $display("FAIL rd_wait: got %b expected 00001", {gnt, rvalid, busy}); end
    @(negedge clk);
    n_tests++; if (rvalid !== 2'b10) begin n_fail++; $display("FAIL rd_rvalid: got %b expected 10", rvalid); end
    n_tests++; if (rdata !== mem_lookup(16'h0010)) begin n_fail++; $display("FAIL rd_rdata: got %h expected %h", rdata, mem_lookup(16'h0010)); end
    n_tests++; if ({parity_err, err_cnt} !== 9'h0) begin n_fail++; $display("FAIL rd_parity: got %b/%0d expected 0/0", parity_err, err_cnt); end
    @(negedge clk);
    n_tests++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL rd_rvalid_pulse: got %b expected 00", rvalid); end
    m_last = 1;
  endtask

  task automatic test_back_to_back();
    int prev, ngr, w;
    logic [DW-1:0] d [NR];
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      d[i] = 8'($urandom);
      set_req(i, 1'b1, AW'(i + 1), d[i]);
    end
    prev = -1;
    ngr = 0;
    for (int cyc = 0; cyc < 40 && ngr < 8; cyc++) begin
      @(negedge clk);
      if (gnt !== 2'b00) begin
        w = rr_pick(2'b11, m_last);
        n_tests++; if (gnt !== (2'b01 << w)) begin n_fail++; $display("FAIL b2b_order: grant %0d got %b expected %b", ngr, gnt, 2'b01 << w); end
        n_tests++; if ({mem_write, mem_address, mem_data_in} !== {1'b1, AW'(w + 1), d[w]}) begin n_fail++; $display("FAIL b2b_txn: got %b/%h/%h expected 1/%h/%h", mem_write, mem_address, mem_data_in, AW'(w + 1), d[w]); end
        n_tests++; if (cyc - prev != ((prev < 0) ? cyc + 1 : 2)) begin n_fail++; $display("FAIL b2b_spacing: got %0d cycles expected %0d", cyc - prev, (prev < 0) ? cyc + 1 : 2); end
        exp_mem[w + 1] = d[w];
        m_last = w;
        prev = cyc;
        ngr++;
        @(posedge clk); #1;
        if (ngr == 8) begin
          req = '0;
        end else begin
          d[w] = 8'($urandom);
          set_req(w, 1'b1, AW'(w + 1), d[w]);
        end
      end
    end
    n_tests++; if (ngr != 8) begin n_fail++; $display("FAIL b2b_timeout: got %0d grants expected 8", ngr); end
    @(negedge clk);
    n_tests++; if ({gnt, busy} !== 3'b000) begin n_fail++; $display("FAIL b2b_idle: got %b expected 000", {gnt, busy}); end
  endtask

  task automatic test_parity();
    int exp_cnt;
    do_reset();
    corrupt = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      set_req(0, 1'b0, 16'h0010, 8'h00);
      @(posedge clk); #1;
      req[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      exp_cnt = (n < 255) ? n : 255;
      if (n <= 2 || n >= 254) begin
        n_tests++; if ({rvalid, parity_err} !== 3'b011) begin n_fail++; $display("FAIL par_pulse: read %0d got %b expected 011", n, {rvalid, parity_err}); end
        n_tests++; if (err_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL par_cnt: read %0d got %0d expected %0d", n, err_cnt, exp_cnt); end
      end
      if (n == 1) begin
        n_tests++; if (rdata !== mem_lookup(16'h0010)) begin n_fail++; $display("FAIL par_rdata: got %h expected %h", rdata, mem_lookup(16'h0010)); end
      end
    end
    m_last = 0;
    corrupt = 1'b0;
    @(posedge clk); #1;
    set_req(0, 1'b0, 16'h0010, 8'h00);
    @(posedge clk); #1;
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if ({rvalid, parity_err, err_cnt} !== {3'b010, 8'd255}) begin n_fail++; $display("FAIL par_clean: got %b/%0d expected 010/255", {rvalid, parity_err}, err_cnt); end
  endtask

  task automatic test_reset_midop();
    logic rv_seen;
    // reset while the READ cycle is driving gnt and mem_read
    @(posedge clk); #1;
    set_req(0, 1'b0, 16'h0001, 8'h00);
    @(posedge clk); #1;
    req[0] = 1'b0;
    n_tests++; if ({gnt, mem_read} !== 3'b011) begin n_fail++; $display("FAIL mid_read_active: got %b expected 011", {gnt, mem_read}); end
    rst_n = 1'b0; #1;
    n_tests++; if ({gnt, mem_read, rvalid, busy} !== 6'b0) begin n_fail++; $display("FAIL mid_read_async: got %b expected 0", {gnt, mem_read, rvalid, busy}); end
    n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_errcnt_clear: got %0d expected 0", err_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    m_last = NR - 1;
    // reset during RWAIT: that read must never report rvalid
    @(posedge clk); #1;
    set_req(0, 1'b0, 16'h0002, 8'h00);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(posedge clk); #1;
    n_tests++; if ({busy, mem_read, gnt} !== 4'b1000) begin n_fail++; $display("FAIL mid_rwait: got %b expected 1000", {busy, mem_read, gnt}); end
    rst_n = 1'b0; #1;
    n_tests++; if ({gnt, mem_read, rvalid, busy} !== 6'b0) begin n_fail++; $display("FAIL mid_rwait_async: got %b expected 0", {gnt, mem_read, rvalid, busy}); end
    @(negedge clk);
    rst_n = 1'b1;
    m_last = NR - 1;
    rv_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rvalid !== 2'b00) rv_seen = 1'b1;
    end
    n_tests++; if (rv_seen !== 1'b0) begin n_fail++; $display("FAIL mid_no_rvalid: got %b expected 0", rv_seen); end
    // both request right after release: requester 0 first
    @(posedge clk); #1;
    set_req(0, 1'b1, 16'h0020, 8'h11);
    set_req(1, 1'b1, 16'h0021, 8'h22);
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL mid_first_gnt: got %b expected 01", gnt); end
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL mid_second_gnt: got %b expected 10", gnt); end
    @(posedge clk); #1;
    req[1] = 1'b0;
    exp_mem[16'h0020] = 8'h11;
    exp_mem[16'h0021] = 8'h22;
    m_last = 1;
  endtask

  task automatic test_drop_req();
    @(posedge clk); #1;
    set_req(0, 1'b1, 16'h0030, 8'h3C);
    @(posedge clk); #1;
    req[0] = 1'b0;
    wdata[7:0] = 8'h00;
    @(negedge clk);
    n_tests++; if ({gnt, mem_write, mem_address, mem_data_in} !== {3'b011, 16'h0030, 8'h3C}) begin n_fail++; $display("FAIL drop_gnt: got %b/%h/%h expected 011/0030/3c", {gnt, mem_write}, mem_address, mem_data_in); end
    exp_mem[16'h0030] = 8'h3C;
    m_last = 0;
    @(posedge clk); #1;
    set_req(1, 1'b0, 16'h0030, 8'h00);
    @(posedge clk); #1;
    req[1] = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if ({rvalid, rdata} !== {2'b10, mem_lookup(16'h0030)}) begin n_fail++; $display("FAIL drop_readback: got %b/%h expected 10/%h", rvalid, rdata, mem_lookup(16'h0030)); end
    m_last = 1;
  endtask

  task automatic test_random();
    logic [NR-1:0] pend, exp_g, exp_rv;
    logic          op_we [NR];
    logic [AW-1:0] op_a [NR];
    logic [DW-1:0] op_d [NR];
    logic [DW-1:0] rd_exp;
    int            w, next_g, rd_due, rd_idx, cyc;
    for (int b = 0; b < 40; b++) begin
      @(posedge clk); #1;
      pend = NR'($urandom_range(1, 3));
      for (int i = 0; i < NR; i++) begin
        if (pend[i]) begin
          op_we[i] = 1'($urandom_range(0, 1));
          op_a[i] = 16'h0040 + AW'($urandom_range(0, 7));
          op_d[i] = 8'($urandom);
          set_req(i, op_we[i], op_a[i], op_d[i]);
        end
      end
      next_g = 1;
      rd_due = -1;
      rd_idx = 0;
      rd_exp = '0;
      cyc = 0;
      while (cyc < 20 && (pend != '0 || rd_due >= 0)) begin
        @(negedge clk);
        exp_g = '0;
        w = -1;
        if (pend != '0 && cyc == next_g) begin
          w = rr_pick(pend, m_last);
          exp_g = 2'b01 << w;
        end
        exp_rv = (rd_due == cyc) ? (2'b01 << rd_idx) : 2'b00;
        n_tests++; if (gnt !== exp_g) begin n_fail++; $display("FAIL rnd_gnt: batch %0d cyc %0d got %b expected %b", b, cyc, gnt, exp_g); end
        n_tests++; if (rvalid !== exp_rv) begin n_fail++; $display("FAIL rnd_rvalid: batch %0d cyc %0d got %b expected %b", b, cyc, rvalid, exp_rv); end
        if (rd_due == cyc) begin
          n_tests++; if ({parity_err, rdata} !== {1'b0, rd_exp}) begin n_fail++; $display("FAIL rnd_rdata: batch %0d got %b/%h expected 0/%h", b, parity_err, rdata, rd_exp); end
          rd_due = -1;
        end
        if (w >= 0) begin
          n_tests++; if ({mem_write, mem_read, mem_address} !== {op_we[w], !op_we[w], op_a[w]}) begin n_fail++; $display("FAIL rnd_mem: batch %0d got %b%b/%h expected %b%b/%h", b, mem_write, mem_read, mem_address, op_we[w], !op_we[w], op_a[w]); end
          pend[w] = 1'b0;
          m_last = w;
          if (op_we[w]) begin
            n_tests++; if (mem_data_in !== op_d[w]) begin n_fail++; $display("FAIL rnd_wdata: batch %0d got %h expected %h", b, mem_data_in, op_d[w]); end
            exp_mem[int'(op_a[w])] = op_d[w];
            next_g = cyc + 2;
          end else begin
            rd_due = cyc + 2;
            rd_idx = w;
            rd_exp = mem_lookup(op_a[w]);
            next_g = cyc + 3;
          end
          @(posedge clk); #1;
          req[w] = 1'b0;
        end
        cyc++;
      end
      n_tests++; if (pend != '0 || rd_due >= 0) begin n_fail++; $display("FAIL rnd_timeout: batch %0d got pend %b rd_due %0d expected none", b, pend, rd_due); end
      req = '0;
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_parity();
    test_reset_midop();
    test_drop_req();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
